noc_switch_reg: RTL and testbench

//   Parametrised switch-traversal (ST) stage of the NoC router: crossbar from INPUT_PORT_NUM inports to OUTPUT_PORT_NUM outports,

---
 rtl/rvh_noc_pkg.sv | 33 +++
 rtl/noc_switch_out_slice.sv | 84 ++++++++
 rtl/noc_switch_reg.sv | 120 ++++++++++++
 tb/tb_noc_switch_reg.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_noc_pkg.sv
// Shared NoC router definitions: port ids, default widths and the
// XY turn mask used by the switch-traversal stage.
package rvh_noc_pkg;

  typedef enum logic [2:0] {
    P_N  = 3'd0,
    P_S  = 3'd1,
    P_E  = 3'd2,
    P_W  = 3'd3,
    P_L0 = 3'd4,
    P_L1 = 3'd5
  } port_id_e;

  localparam int VC_ID_NUM_MAX_W = 3;
  localparam int NOC_FLIT_W      = 256;
  localparam int TURN_MASK_W     = 256;

  // Bit [o*in_n+i] set: inport i may feed outport o. U-turns are never legal.
  function automatic logic [TURN_MASK_W-1:0] xy_turn_mask(
    input int in_n,
    input int out_n
  );
    logic [TURN_MASK_W-1:0] m;
    m = '0;
    for (int o = 0; o < out_n; o++) begin
      for (int i = 0; i < in_n; i++) begin
        m[o*in_n+i] = (o != i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/noc_switch_out_slice.sv
// One crossbar output: inport mux, legality check and output registers.
// SWITCH_PERF_CNT_EN adds a saturating per-outport flit counter.
module noc_switch_out_slice
  import rvh_noc_pkg::*;
#(
  parameter int IN      = 6,
  parameter int FLIT_W  = NOC_FLIT_W,
  parameter int VC_ID_W = VC_ID_NUM_MAX_W,
  parameter int LAR_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN*FLIT_W-1:0] in_flit,
  input  logic [IN-1:0]        in_ok,
  input  logic [IN-1:0]        mask,
  input  logic                 vld,
  input  logic [VC_ID_W-1:0]   sel,
  input  logic [VC_ID_W-1:0]   vc_id,
  input  logic [LAR_W-1:0]     lar,
`ifdef SWITCH_PERF_CNT_EN
  input  logic                 perf_cnt_clr_i,
  output logic [31:0]          perf_cnt_o,
`endif
  output logic                 pend,
  output logic                 illegal,
  output logic                 v_q,
  output logic [FLIT_W-1:0]    flit_q,
  output logic [VC_ID_W-1:0]   vc_q,
  output logic [LAR_W-1:0]     lar_q
);

  logic              hit;
  logic [FLIT_W-1:0] mux;

  // Out-of-range sel never matches, so it falls out as illegal.
  always_comb begin
    hit = 1'b0;
    mux = '0;
    for (int i = 0; i < IN; i++) begin
      if (int'(sel) == i) begin
        hit = mask[i] & in_ok[i];
        mux = in_flit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign pend    = vld & hit;
  assign illegal = vld & ~hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      flit_q <= '0;
      vc_q   <= '0;
      lar_q  <= '0;
    end else begin
      v_q <= pend;
      if (pend) begin
        flit_q <= mux;
        vc_q   <= vc_id;
        lar_q  <= lar;
      end
    end
  end

`ifdef SWITCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (perf_cnt_clr_i) begin
      cnt_q <= '0;
    end else if (v_q && cnt_q != 32'hFFFF_FFFF) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign perf_cnt_o = cnt_q;
`else
  // no flit counter in this build
`endif

endmodule

// File: rtl/noc_switch_reg.sv
// NoC router switch-traversal stage: registered crossbar, sticky errors.
// Optional SWITCH_PERF_CNT_EN adds perf_cnt_o / perf_cnt_clr_i.
module noc_switch_reg
  import rvh_noc_pkg::*;
#(
  parameter int INPUT_PORT_NUM  = 6,
  parameter int OUTPUT_PORT_NUM = 6,
  parameter int FLIT_W          = NOC_FLIT_W,
  parameter int VC_NUM_MAX      = 4,
  parameter int VC_ID_W         = VC_ID_NUM_MAX_W,
  parameter int LAR_W           = 3,
  parameter logic [TURN_MASK_W-1:0] TURN_MASK =
    xy_turn_mask(INPUT_PORT_NUM, OUTPUT_PORT_NUM)
) (
  input  logic clk,
  input  logic rst,
  input  logic [INPUT_PORT_NUM*VC_NUM_MAX*FLIT_W-1:0]
               vc_data_head_i,
  input  logic [INPUT_PORT_NUM-1:0] inport_read_enable_st_i,
  input  logic [INPUT_PORT_NUM*VC_ID_W-1:0]
               inport_read_vc_id_st_i,
  input  logic [OUTPUT_PORT_NUM-1:0] outport_vld_st_i,
  input  logic [OUTPUT_PORT_NUM*VC_ID_W-1:0]
               outport_sel_inport_id_st_i,
  input  logic [OUTPUT_PORT_NUM*VC_ID_W-1:0]
               outport_vc_id_st_i,
  input  logic [OUTPUT_PORT_NUM*LAR_W-1:0]
               outport_lar_st_i,
  input  logic err_clr_i,
`ifdef SWITCH_PERF_CNT_EN
  input  logic perf_cnt_clr_i,
  output logic [OUTPUT_PORT_NUM*32-1:0] perf_cnt_o,
`endif
  output logic [OUTPUT_PORT_NUM-1:0] tx_flit_pend_o,
  output logic [OUTPUT_PORT_NUM-1:0] tx_flit_v_o,
  output logic [OUTPUT_PORT_NUM*FLIT_W-1:0] tx_flit_o,
  output logic [OUTPUT_PORT_NUM*VC_ID_W-1:0] tx_flit_vc_id_o,
  output logic [OUTPUT_PORT_NUM*LAR_W-1:0] tx_flit_lar_o,
  output logic err_o,
  output logic [VC_ID_W-1:0] err_outport_o
);

  localparam int IN  = INPUT_PORT_NUM;
  localparam int OUT = OUTPUT_PORT_NUM;

  logic [IN*FLIT_W-1:0] in_flit;
  logic [IN-1:0]        in_ok;
  logic [OUT-1:0]       illegal;
  logic [VC_ID_W-1:0]   first_ill;
  logic [VC_ID_W-1:0]   rvc;

  // Per inport: head flit of the VC being read, and whether that read is usable.
  always_comb begin
    in_flit = '0;
    in_ok   = '0;
    rvc     = '0;
    for (int i = 0; i < IN; i++) begin
      rvc      = inport_read_vc_id_st_i[i*VC_ID_W +: VC_ID_W];
      in_ok[i] = inport_read_enable_st_i[i] &
                 (int'(rvc) < VC_NUM_MAX);
      for (int v = 0; v < VC_NUM_MAX; v++) begin
        if (int'(rvc) == v) begin
          in_flit[i*FLIT_W +: FLIT_W] =
            vc_data_head_i[(i*VC_NUM_MAX+v)*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  for (genvar o = 0; o < OUT; o++) begin : g_out
    noc_switch_out_slice #(
      .IN      (IN),
      .FLIT_W  (FLIT_W),
      .VC_ID_W (VC_ID_W),
      .LAR_W   (LAR_W)
    ) u_slice (
      .clk            (clk),
      .rst            (rst),
      .in_flit        (in_flit),
      .in_ok          (in_ok),
      .mask           (TURN_MASK[o*IN +: IN]),
      .vld            (outport_vld_st_i[o]),
      .sel            (outport_sel_inport_id_st_i[o*VC_ID_W +: VC_ID_W]),
      .vc_id          (outport_vc_id_st_i[o*VC_ID_W +: VC_ID_W]),
      .lar            (outport_lar_st_i[o*LAR_W +: LAR_W]),
`ifdef SWITCH_PERF_CNT_EN
      .perf_cnt_clr_i (perf_cnt_clr_i),
      .perf_cnt_o     (perf_cnt_o[o*32 +: 32]),
`endif
      .pend           (tx_flit_pend_o[o]),
      .illegal        (illegal[o]),
      .v_q            (tx_flit_v_o[o]),
      .flit_q         (tx_flit_o[o*FLIT_W +: FLIT_W]),
      .vc_q           (tx_flit_vc_id_o[o*VC_ID_W +: VC_ID_W]),
      .lar_q          (tx_flit_lar_o[o*LAR_W +: LAR_W])
    );
  end

  // Descending scan so the lowest illegal outport ends up selected.
  always_comb begin
    first_ill = '0;
    for (int o = OUT - 1; o >= 0; o--) begin
      if (illegal[o]) first_ill = VC_ID_W'(o);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o         <= 1'b0;
      err_outport_o <= '0;
    end else if (|illegal) begin
      err_o <= 1'b1;
      if (!err_o || err_clr_i) err_outport_o <= first_ill;
    end else if (err_clr_i) begin
      err_o         <= 1'b0;
      err_outport_o <= '0;
    end
  end

endmodule

// File: tb/tb_noc_switch_reg.sv
// Scoreboard bench for noc_switch_reg: directed cycles push expectations,
// a monitor pops and compares one entry per clock.
module tb_noc_switch_reg;

  localparam int IN  = 6;
  localparam int OUT = 6;
  localparam int FW  = 256;
  localparam int VN  = 4;
  localparam int VW  = 3;
  localparam int LW  = 3;

  typedef struct packed {
    logic [OUT-1:0]    v;
    logic [OUT*FW-1:0] f;
    logic [OUT*VW-1:0] vc;
    logic [OUT*LW-1:0] lar;
    logic              err;
    logic [VW-1:0]     eo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [FW-1:0] head [IN][VN];
  logic [IN-1:0] rd_en;
  logic [VW-1:0] rd_vc [IN];
  logic [OUT-1:0] vld;
  logic [VW-1:0] sel [OUT];
  logic [VW-1:0] ovc [OUT];
  logic [LW-1:0] lar [OUT];
  logic err_clr;

  logic [IN*VN*FW-1:0] head_bus;
  logic [IN*VW-1:0]    rd_vc_bus;
  logic [OUT*VW-1:0]   sel_bus;
  logic [OUT*VW-1:0]   ovc_bus;
  logic [OUT*LW-1:0]   lar_bus;

  always_comb begin
    head_bus  = '0;
    rd_vc_bus = '0;
    sel_bus   = '0;
    ovc_bus   = '0;
    lar_bus   = '0;
    for (int i = 0; i < IN; i++) begin
      rd_vc_bus[i*VW +: VW] = rd_vc[i];
      for (int v = 0; v < VN; v++)
        head_bus[(i*VN+v)*FW +: FW] = head[i][v];
    end
    for (int o = 0; o < OUT; o++) begin
      sel_bus[o*VW +: VW] = sel[o];
      ovc_bus[o*VW +: VW] = ovc[o];
      lar_bus[o*LW +: LW] = lar[o];
    end
  end

  logic [OUT-1:0]    pend;
  logic [OUT-1:0]    tv;
  logic [OUT*FW-1:0] tf;
  logic [OUT*VW-1:0] tvc;
  logic [OUT*LW-1:0] tlar;
  logic              err;
  logic [VW-1:0]     eo;
`ifdef SWITCH_PERF_CNT_EN
  logic              perf_clr = 1'b0;
  logic [OUT*32-1:0] perf_cnt;
`endif

  noc_switch_reg dut (
    .clk                        (clk),
    .rst                        (rst),
    .vc_data_head_i             (head_bus),
    .inport_read_enable_st_i    (rd_en),
    .inport_read_vc_id_st_i     (rd_vc_bus),
    .outport_vld_st_i           (vld),
    .outport_sel_inport_id_st_i (sel_bus),
    .outport_vc_id_st_i         (ovc_bus),
    .outport_lar_st_i           (lar_bus),
    .err_clr_i                  (err_clr),
`ifdef SWITCH_PERF_CNT_EN
    .perf_cnt_clr_i             (perf_clr),
    .perf_cnt_o                 (perf_cnt),
`endif
    .tx_flit_pend_o             (pend),
    .tx_flit_v_o                (tv),
    .tx_flit_o                  (tf),
    .tx_flit_vc_id_o            (tvc),
    .tx_flit_lar_o              (tlar),
    .err_o                      (err),
    .err_outport_o              (eo)
  );

  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [OUT*FW-1:0] m_f   = '0;
  logic [OUT*VW-1:0] m_vc  = '0;
  logic [OUT*LW-1:0] m_lar = '0;
  logic              m_err = 1'b0;
  logic [VW-1:0]     m_eo  = '0;

  task automatic chk(input string nm, input logic [FW-1:0] a,
                     input logic [FW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_zero_all(input string nm);
    chk({nm, "_v"}, FW'(tv), '0);
    chk({nm, "_vc"}, FW'(tvc), '0);
    chk({nm, "_lar"}, FW'(tlar), '0);
    chk({nm, "_err"}, FW'(err), '0);
    chk({nm, "_eo"}, FW'(eo), '0);
    for (int o = 0; o < OUT; o++)
      chk($sformatf("%s_flit%0d", nm, o), tf[o*FW +: FW], '0);
  endtask

  task automatic idle();
    rd_en   = '0;
    vld     = '0;
    err_clr = 1'b0;
    for (int i = 0; i < IN; i++) rd_vc[i] = '0;
    for (int o = 0; o < OUT; o++) begin
      sel[o] = '0;
      ovc[o] = '0;
      lar[o] = '0;
    end
  endtask

  // legal/ill are hand-derived for each directed cycle
  task automatic step(input logic [OUT-1:0] legal,
                      input logic [OUT-1:0] ill,
                      input logic clr);
    exp_t e;
    logic [VW-1:0] first;
    logic [VW-1:0] s;
    err_clr = clr;
    #1;
    chk("pend", FW'(pend), FW'(legal));
    for (int o = 0; o < OUT; o++) begin
      if (legal[o]) begin
        s = sel[o];
        m_f[o*FW +: FW]   = head[s][rd_vc[s]];
        m_vc[o*VW +: VW]  = ovc[o];
        m_lar[o*LW +: LW] = lar[o];
      end
    end
    if (|ill) begin
      first = '0;
      for (int o = OUT - 1; o >= 0; o--)
        if (ill[o]) first = VW'(o);
      if (!m_err || clr) m_eo = first;
      m_err = 1'b1;
    end else if (clr) begin
      m_err = 1'b0;
      m_eo  = '0;
    end
    e.v   = legal;
    e.f   = m_f;
    e.vc  = m_vc;
    e.lar = m_lar;
    e.err = m_err;
    e.eo  = m_eo;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("v", FW'(tv), FW'(e.v));
        for (int o = 0; o < OUT; o++)
          chk($sformatf("flit%0d", o), tf[o*FW +: FW], e.f[o*FW +: FW]);
        chk("vc_id", FW'(tvc), FW'(e.vc));
        chk("lar", FW'(tlar), FW'(e.lar));
        chk("err", FW'(err), FW'(e.err));
        chk("err_outport", FW'(eo), FW'(e.eo));
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < IN; i++)
      for (int v = 0; v < VN; v++)
        head[i][v] = {32{8'(i*16 + v)}};
    head[0][1] = {32{8'hA5}};
    idle();
    #7;
    chk_zero_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // N vc1 -> E
    @(negedge clk);
    idle();
    rd_en[0] = 1'b1; rd_vc[0] = 3'd1;
    vld[2] = 1'b1; sel[2] = 3'd0; ovc[2] = 3'd2; lar[2] = 3'd5;
    step(6'b000100, 6'b0, 1'b0);
    @(negedge clk);
    idle();
    step(6'b0, 6'b0, 1'b0);

    // W vc3 multicast to S and L0, four back-to-back flits
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      head[3][3] = {32{8'(8'hC0 + k)}};
      rd_en[3] = 1'b1; rd_vc[3] = 3'd3;
      vld[1] = 1'b1; sel[1] = 3'd3; ovc[1] = 3'd1; lar[1] = 3'd2;
      vld[4] = 1'b1; sel[4] = 3'd3; ovc[4] = VW'(k); lar[4] = 3'd4;
      step(6'b010010, 6'b0, 1'b0);
    end
    @(negedge clk);
    idle();
    step(6'b0, 6'b0, 1'b0);

    // N u-turn
    @(negedge clk);
    idle();
    rd_en[0] = 1'b1;
    vld[0] = 1'b1; sel[0] = 3'd0;
    step(6'b0, 6'b000001, 1'b0);
    // E u-turn alongside legal E -> N
    @(negedge clk);
    idle();
    rd_en[2] = 1'b1; rd_vc[2] = 3'd2;
    vld[2] = 1'b1; sel[2] = 3'd2;
    vld[0] = 1'b1; sel[0] = 3'd2; ovc[0] = 3'd7; lar[0] = 3'd3;
    step(6'b000001, 6'b000100, 1'b0);
    // sel out of range, inport not read, vc id out of range
    @(negedge clk);
    idle();
    vld[1] = 1'b1; sel[1] = 3'd7;
    vld[3] = 1'b1; sel[3] = 3'd0;
    rd_en[2] = 1'b1; rd_vc[2] = 3'd5;
    vld[5] = 1'b1; sel[5] = 3'd2;
    step(6'b0, 6'b101010, 1'b0);

    // clear collides with new illegal on W
    @(negedge clk);
    idle();
    rd_en[3] = 1'b1;
    vld[3] = 1'b1; sel[3] = 3'd3;
    step(6'b0, 6'b001000, 1'b1);
    @(negedge clk);
    idle();
    step(6'b0, 6'b0, 1'b1);
    // simultaneous illegal on S and W
    @(negedge clk);
    idle();
    rd_en[1] = 1'b1; rd_en[3] = 1'b1;
    vld[1] = 1'b1; sel[1] = 3'd1;
    vld[3] = 1'b1; sel[3] = 3'd3;
    step(6'b0, 6'b001010, 1'b0);
    @(negedge clk);
    idle();
    step(6'b0, 6'b0, 1'b1);

    // async reset while a flit is on the output
    @(negedge clk);
    idle();
    rd_en[0] = 1'b1; rd_vc[0] = 3'd1;
    vld[2] = 1'b1; sel[2] = 3'd0; ovc[2] = 3'd6; lar[2] = 3'd1;
    step(6'b000100, 6'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero_all("midrst");
    m_f = '0; m_vc = '0; m_lar = '0; m_err = 1'b0; m_eo = '0;
    @(negedge clk);
    rst = 1'b0;
    idle();
    rd_en[2] = 1'b1; rd_vc[2] = 3'd2;
    vld[4] = 1'b1; sel[4] = 3'd2; ovc[4] = 3'd3; lar[4] = 3'd7;
    step(6'b010000, 6'b0, 1'b0);
    @(negedge clk);
    idle();
    step(6'b0, 6'b0, 1'b0);

`ifdef SWITCH_PERF_CNT_EN
    @(negedge clk);
    idle();
    perf_clr = 1'b1;
    step(6'b0, 6'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      perf_clr = 1'b0;
      idle();
      rd_en[0] = 1'b1; rd_vc[0] = 3'd1;
      vld[2] = 1'b1; sel[2] = 3'd0;
      step(6'b000100, 6'b0, 1'b0);
    end
    @(negedge clk);
    idle();
    step(6'b0, 6'b0, 1'b0);
    @(negedge clk);
    chk("perf_cnt_e", FW'(perf_cnt[2*32 +: 32]), FW'(32'd3));
    idle();
    rd_en[0] = 1'b1; rd_vc[0] = 3'd1;
    vld[2] = 1'b1; sel[2] = 3'd0;
    step(6'b000100, 6'b0, 1'b0);
    @(negedge clk);
    perf_clr = 1'b1;
    step(6'b000100, 6'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("perf_clr_wins", FW'(perf_cnt[2*32 +: 32]), '0);
    @(negedge clk);
    perf_clr = 1'b0;
    idle();
    step(6'b0, 6'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
